// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mau_pkg
// Description : Shared types and default sizes for the memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mau_pkg;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } mau_state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } mau_kind_e;

endpackage
`default_nettype wire

// File: rtl/mau_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mau_timeout_ctr
// Description : WAIT-cycle counter for the memory access unit. Held at zero
//               while clr is high; flags expired during the TIMEOUT-th
//               enabled cycle. Only instantiated when MAU_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module mau_timeout_ctr #(
  parameter int TIMEOUT = mau_pkg::DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The current cycle is the TIMEOUT-th one when TIMEOUT-1 cycles have passed.
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear, or advance while enabled and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Converts the controller's level-held memory strobes into one
//               handshaked memory transaction per request, owns IR and MDR,
//               and pulses done on completion.
//               Optional WAIT timeout with sticky err: define MAU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int WORD_W  = mau_pkg::DEF_WORD_W,
  parameter int TIMEOUT = mau_pkg::DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              i_or_d,
  input  logic              ir_write,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] b_data,
  output logic [WORD_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] mdr,
  output logic              done,
  output logic              busy,
  output logic              err
);

  import mau_pkg::*;

  mau_state_e        state_q, state_d;
  mau_kind_e         kind_q, kind_d;
  logic              irw_q, irw_d;
  logic              m_rd_q, m_rd_d;
  logic              m_wr_q, m_wr_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] m_addr_q, m_addr_d;
  logic [WORD_W-1:0] m_wdata_q, m_wdata_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic              in_wait;
  logic              expired;

  assign in_wait = (state_q == WAIT);

`ifdef MAU_TIMEOUT_EN
  mau_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (expired)
  );
`else
  // Without the timeout option WAIT only ends on m_ack; TIMEOUT has no effect.
  logic unused_timeout;
  assign unused_timeout = in_wait && (TIMEOUT != 0);
  assign expired        = 1'b0;
`endif

  // Next-state and datapath updates; read wins over write when both requested.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    irw_d     = irw_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    err_d     = err_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    instr_d   = instr_q;
    mdr_d     = mdr_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d   = WAIT;
          m_addr_d  = i_or_d ? alu_out : pc;
          m_wdata_d = b_data;
          kind_d    = mem_read ? RD : WR;
          irw_d     = ir_write;
          m_rd_d    = mem_read;
          m_wr_d    = !mem_read;
        end
      end
      WAIT: begin
        if (m_ack) begin
          state_d = DONE;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          if (kind_q == RD) begin
            mdr_d = m_rdata;
            if (irw_q) begin
              instr_d = m_rdata;
            end
          end
        end else if (expired) begin
          state_d = DONE;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = HOLD;
      end
      HOLD: begin
        // Wait for the controller to drop its level request before re-arming.
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any pending access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      kind_q    <= RD;
      irw_q     <= 1'b0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      err_q     <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      instr_q   <= '0;
      mdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      irw_q     <= irw_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      err_q     <= err_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      instr_q   <= instr_d;
      mdr_q     <= mdr_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_rd    = m_rd_q;
  assign m_wr    = m_wr_q;
  assign m_wdata = m_wdata_q;
  assign instr   = instr_q;
  assign mdr     = mdr_q;
  assign err     = err_q;
  assign done    = (state_q == DONE);
  assign busy    = (state_q == WAIT) || (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Expected IR/MDR
//               contents are queued per request and compared on each done.
//               Timeout cases are exercised when MAU_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int W  = 16;
  localparam int TO = 15;

  typedef struct packed {
    logic [W-1:0] mdr;
    logic [W-1:0] instr;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0, i_or_d = 1'b0, ir_write = 1'b0;
  logic [W-1:0] pc = '0, alu_out = '0, b_data = '0, m_rdata = '0;
  logic         m_ack = 1'b0;
  logic [W-1:0] m_addr, m_wdata, instr, mdr;
  logic         m_rd, m_wr, done, busy, err;

  int   n_vec = 0;
  int   n_miss = 0;
  int   n_rd_tx = 0, n_wr_tx = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  exp_t sb[$];
  exp_t sb_e;
  logic [W-1:0] mdl_mdr = '0, mdl_instr = '0;
  logic         mdl_err = 1'b0;

  mem_access_unit #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc(pc), .alu_out(alu_out),
    .b_data(b_data), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .instr(instr),
    .mdr(mdr), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard pop on done; strobe rising edges counted as transactions.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check_eq("done_unexpected", done, 1'b0);
      end else begin
        sb_e = sb.pop_front();
        check_eq("sb_mdr", mdr, sb_e.mdr);
        check_eq("sb_instr", instr, sb_e.instr);
      end
    end
    if (m_rd && !prev_rd) n_rd_tx++;
    if (m_wr && !prev_wr) n_wr_tx++;
    prev_rd = m_rd;
    prev_wr = m_wr;
  end

  // One access from IDLE: ack driven in cycle ack_k, requests dropped at cycle req_cyc.
  task automatic access(input logic rd, input logic wr, input logic iod, input logic irw,
                        input logic [W-1:0] p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] rdat, input int ack_k, input int req_cyc);
    int e, last, rd0, wr0;
    bit to, exp_rd, exp_wr;
    logic [W-1:0] exp_addr;
    e = ack_k;
    to = 1'b0;
`ifdef MAU_TIMEOUT_EN
    if (ack_k > TO) begin
      e  = TO;
      to = 1'b1;
    end
`endif
    exp_rd   = rd;
    exp_wr   = wr && !rd;
    exp_addr = iod ? a : p;
    if (exp_rd && !to) begin
      mdl_mdr = rdat;
      if (irw) mdl_instr = rdat;
    end
    sb.push_back('{mdr: mdl_mdr, instr: mdl_instr});
    rd0  = n_rd_tx;
    wr0  = n_wr_tx;
    last = (e + 3 > req_cyc + 1) ? e + 3 : req_cyc + 1;
    mem_read = rd; mem_write = wr; i_or_d = iod; ir_write = irw;
    pc = p; alu_out = a; b_data = b;
    for (int cyc = 0; cyc < last; cyc++) begin
      if (cyc == req_cyc) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (cyc == 1) begin
        pc = ~p; alu_out = ~a; b_data = ~b;
      end
      m_ack   = (cyc == ack_k);
      m_rdata = (cyc == ack_k) ? rdat : 16'hDEAD;
      @(negedge clk);
      if (cyc >= 1 && cyc <= e) begin
        check_eq("m_rd", m_rd, exp_rd);
        check_eq("m_wr", m_wr, exp_wr);
        check_eq("m_addr", m_addr, exp_addr);
        check_eq("m_wdata", m_wdata, b);
      end else begin
        check_eq("strobe_idle", {m_rd, m_wr}, 2'b00);
      end
      check_eq("done", done, cyc == e + 1);
      check_eq("busy", busy, (cyc >= 1) && (cyc <= e + 1));
      check_eq("err", err, mdl_err || (to && cyc >= e + 1));
      @(posedge clk);
      #1;
    end
    m_ack   = 1'b0;
    mdl_err = mdl_err || to;
    check_eq("rd_tx_count", n_rd_tx - rd0, exp_rd);
    check_eq("wr_tx_count", n_wr_tx - wr0, exp_wr);
  endtask

  initial begin
    int rw;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_m_rd", m_rd, 1'b0);
    check_eq("rst_m_wr", m_wr, 1'b0);
    check_eq("rst_m_addr", m_addr, 16'h0000);
    check_eq("rst_instr", instr, 16'h0000);
    check_eq("rst_mdr", mdr, 16'h0000);
    check_eq("rst_done_busy_err", {done, busy, err}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fetch, store, load without IR, simultaneous read and write.
    access(1, 0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 16'h6A05, 1, 4);
    access(0, 1, 1, 0, 16'h0100, 16'h0040, 16'hBEEF, 16'h0000, 3, 2);
    access(1, 0, 1, 0, 16'h0020, 16'h0080, 16'h0000, 16'h1234, 2, 3);
    access(1, 1, 0, 1, 16'h0200, 16'h0300, 16'h5555, 16'hA5A5, 1, 2);

    // Spurious ack in IDLE is ignored.
    m_ack = 1'b1; m_rdata = 16'hFFFF;
    @(negedge clk);
    @(posedge clk);
    #1;
    m_ack = 1'b0;
    @(negedge clk);
    check_eq("spur_busy_done", {busy, done, m_rd, m_wr}, 4'b0000);
    check_eq("spur_mdr", mdr, mdl_mdr);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of WAIT.
    mem_read = 1'b1; ir_write = 1'b1; i_or_d = 1'b0; pc = 16'h0300;
    @(posedge clk);
    #1;
    check_eq("pre_rst_m_rd", m_rd, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_m_rd", m_rd, 1'b0);
    check_eq("arst_done_busy", {done, busy}, 2'b00);
    check_eq("arst_instr", instr, 16'h0000);
    check_eq("arst_mdr", mdr, 16'h0000);
    check_eq("arst_m_addr", m_addr, 16'h0000);
    mem_read = 1'b0;
    mdl_mdr = '0; mdl_instr = '0; mdl_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    access(1, 0, 1, 1, 16'h0000, 16'h0404, 16'h0000, 16'h7E57, 2, 1);

    // Random mix of accesses.
    for (int i = 0; i < 6; i++) begin
      rw = $urandom_range(1, 3);
      access(rw[0], rw[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(1, 5), $urandom_range(1, 7));
    end

`ifdef MAU_TIMEOUT_EN
    // Ack on the timeout cycle wins; then a real timeout; err stays sticky.
    access(1, 0, 0, 1, 16'h0050, 16'h0000, 16'h0000, 16'hC0DE, TO, 3);
    access(1, 0, 0, 1, 16'h0060, 16'h0000, 16'h0000, 16'hFFFF, 40, 2);
    access(0, 1, 1, 0, 16'h0000, 16'h0070, 16'h1111, 16'h0000, 1, 1);
    check_eq("err_sticky", err, 1'b1);
`endif

    check_eq("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
